// File: rtl/ic_test_sequencer_if.sv
// Signal bundle between the IC-identification sequencer, its front-panel
// controls and the logical-function checker it drives.
interface ic_test_sequencer_if;
    logic        start;
    logic        scan_mode;
    logic        icg;
    logic        chk_pass;
    logic        chk_fail;
    logic [2:0]  tester;
    logic [2:0]  gate;
    logic        icg_out;
    logic        busy;
    logic        done;
    logic        id_valid;
    logic [3:0]  id_index;
    logic        not_found;
    logic        timeout;
    logic        aborted;
    logic [13:0] pass_map;

    modport master (
        output start, scan_mode, icg, chk_pass, chk_fail,
        input  tester, gate, icg_out, busy, done, id_valid, id_index, not_found,
               timeout, aborted, pass_map
    );

    modport slave (
        input  start, scan_mode, icg, chk_pass, chk_fail,
        output tester, gate, icg_out, busy, done, id_valid, id_index, not_found,
               timeout, aborted, pass_map
    );
endinterface

// File: rtl/ic_test_sequencer.sv
// Walks a fixed table of 14 (tester, gate) candidates through the checker,
// clearing it before each one and recording pass/fail/timeout results.
module ic_test_sequencer #(
    parameter int unsigned CLEAR_CYCLES   = 4,
    parameter int unsigned SETTLE_CYCLES  = 12500005,
    parameter int unsigned TIMEOUT_CYCLES = 37500015,
    parameter int unsigned CNT_W          = 32
) (
    input logic               clk,
    input logic               reset_n,
    ic_test_sequencer_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StClear, StSettle, StWait, StRecord, StDone} state_e;

    localparam logic [CNT_W-1:0] ClearLast   = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] SettleLast  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LastIdx     = 4'd13;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q;
    logic             scan_q, scan_d;
    logic [3:0]       idx_q, idx_d;
    logic [2:0]       tester_q, tester_d;
    logic [2:0]       gate_q, gate_d;
    logic             cand_pass_q, cand_pass_d;
    logic             id_valid_q, id_valid_d;
    logic [3:0]       id_index_q, id_index_d;
    logic             not_found_q, not_found_d;
    logic             timeout_q, timeout_d;
    logic             aborted_q, aborted_d;
    logic [13:0]      pass_map_q, pass_map_d;
    logic             start_rise;
    logic             active;
    logic             abort;

    function automatic logic [5:0] cand_sel(input logic [3:0] i);
        logic [2:0] t;
        logic [2:0] g;
        if (i == 4'd0) begin
            t = 3'd0; g = 3'd0;
        end else if (i <= 4'd6) begin
            t = 3'd1; g = 3'(i - 4'd1);
        end else if (i <= 4'd9) begin
            t = 3'd2; g = 3'(i - 4'd7);
        end else if (i <= 4'd11) begin
            t = 3'd3; g = 3'(i - 4'd10);
        end else begin
            t = 3'd4; g = 3'(i - 4'd12);
        end
        return {t, g};
    endfunction

    assign start_rise = bus.start & ~start_q;
    assign active     = state_q inside {StClear, StSettle, StWait, StRecord};
    assign abort      = active & ~bus.icg;

    always_comb begin
        state_d     = state_q;
        scan_d      = scan_q;
        idx_d       = idx_q;
        tester_d    = tester_q;
        gate_d      = gate_q;
        cand_pass_d = cand_pass_q;
        id_valid_d  = id_valid_q;
        id_index_d  = id_index_q;
        not_found_d = not_found_q;
        timeout_d   = timeout_q;
        aborted_d   = aborted_q;
        pass_map_d  = pass_map_q;

        if (abort) begin
            // pass_map and timeout survive an abort for post-mortem inspection
            state_d     = StIdle;
            aborted_d   = 1'b1;
            id_valid_d  = 1'b0;
            not_found_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_rise && bus.icg) begin
                        id_valid_d          = 1'b0;
                        id_index_d          = 4'd0;
                        not_found_d         = 1'b0;
                        timeout_d           = 1'b0;
                        aborted_d           = 1'b0;
                        pass_map_d          = '0;
                        scan_d              = bus.scan_mode;
                        idx_d               = 4'd0;
                        {tester_d, gate_d}  = cand_sel(4'd0);
                        state_d             = StClear;
                    end
                end
                StClear: if (cnt_q == ClearLast) state_d = StSettle;
                StSettle: if (cnt_q == SettleLast) state_d = StWait;
                StWait: begin
                    // fail dominates a simultaneous pass
                    if (bus.chk_fail) begin
                        cand_pass_d = 1'b0;
                        state_d     = StRecord;
                    end else if (bus.chk_pass) begin
                        cand_pass_d       = 1'b1;
                        pass_map_d[idx_q] = 1'b1;
                        state_d           = StRecord;
                    end else if (cnt_q == TimeoutLast) begin
                        cand_pass_d = 1'b0;
                        timeout_d   = 1'b1;
                        state_d     = StRecord;
                    end
                end
                StRecord: begin
                    if (cand_pass_q && !scan_q) begin
                        id_valid_d = 1'b1;
                        id_index_d = idx_q;
                        state_d    = StDone;
                    end else begin
                        if (cand_pass_q && !id_valid_q) begin
                            id_valid_d = 1'b1;
                            id_index_d = idx_q;
                        end
                        if (idx_q == LastIdx) begin
                            state_d = StDone;
                        end else begin
                            idx_d              = idx_q + 4'd1;
                            {tester_d, gate_d} = cand_sel(idx_q + 4'd1);
                            state_d            = StClear;
                        end
                    end
                end
                StDone: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end

        // not_found is valid alongside the done pulse
        if (state_d == StDone) not_found_d = ~id_valid_d;

        if (state_d != state_q || state_q == StIdle) cnt_d = '0;
        else                                          cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            scan_q      <= 1'b0;
            idx_q       <= 4'd0;
            tester_q    <= 3'd0;
            gate_q      <= 3'd0;
            cand_pass_q <= 1'b0;
            id_valid_q  <= 1'b0;
            id_index_q  <= 4'd0;
            not_found_q <= 1'b0;
            timeout_q   <= 1'b0;
            aborted_q   <= 1'b0;
            pass_map_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_q     <= bus.start;
            scan_q      <= scan_d;
            idx_q       <= idx_d;
            tester_q    <= tester_d;
            gate_q      <= gate_d;
            cand_pass_q <= cand_pass_d;
            id_valid_q  <= id_valid_d;
            id_index_q  <= id_index_d;
            not_found_q <= not_found_d;
            timeout_q   <= timeout_d;
            aborted_q   <= aborted_d;
            pass_map_q  <= pass_map_d;
        end
    end

    assign bus.tester    = tester_q;
    assign bus.gate      = gate_q;
    assign bus.icg_out   = state_q inside {StSettle, StWait, StRecord};
    assign bus.busy      = active;
    assign bus.done      = (state_q == StDone);
    assign bus.id_valid  = id_valid_q;
    assign bus.id_index  = id_index_q;
    assign bus.not_found = not_found_q;
    assign bus.timeout   = timeout_q;
    assign bus.aborted   = aborted_q;
    assign bus.pass_map  = pass_map_q;

endmodule

// File: tb/tb_ic_test_sequencer.sv
// Directed bench for ic_test_sequencer with a behavioural checker model that
// passes, fails or stays silent depending on the selected candidate.
module tb_ic_test_sequencer;

    localparam int unsigned CLR = 2;
    localparam int unsigned STL = 5;
    localparam int unsigned TMO = 8;

    localparam logic [2:0] TAB_T [14] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1,
                                          3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4};
    localparam logic [2:0] TAB_G [14] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                                          3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd0, 3'd1};

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    ic_test_sequencer_if bus ();

    ic_test_sequencer #(
        .CLEAR_CYCLES  (CLR),
        .SETTLE_CYCLES (STL),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (32)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checker model: mode 0 = mask decides, 1 = silent, 2 = pass+fail together at index 0
    int          mode;
    logic [13:0] mask;
    int          model_idx;

    function automatic int idx_of(input logic [2:0] t, input logic [2:0] g);
        case (t)
            3'd0:    return 0;
            3'd1:    return 1 + int'(g);
            3'd2:    return 7 + int'(g);
            3'd3:    return 10 + int'(g);
            3'd4:    return 12 + int'(g);
            default: return 0;
        endcase
    endfunction

    assign model_idx = idx_of(bus.tester, bus.gate);

    always_comb begin
        bus.chk_pass = 1'b0;
        bus.chk_fail = 1'b0;
        if (bus.icg_out && model_idx < 14) begin
            if (mode == 2 && model_idx == 0) begin
                bus.chk_pass = 1'b1;
                bus.chk_fail = 1'b1;
            end else if (mode != 1) begin
                bus.chk_pass = mask[model_idx];
                bus.chk_fail = ~mask[model_idx];
            end
        end
    end

    logic [2:0] vt [16];
    logic [2:0] vg [16];
    int         visits;
    int         clear_bad;

    // Pulses start, then logs each candidate at settle entry and the clear length before it.
    task automatic run_seq(input int budget, input bit hold, input int abort_visit,
                           output int done_at);
        int   clen;
        logic prev;
        visits    = 0;
        clear_bad = 0;
        done_at   = -1;
        clen      = 0;
        prev      = 1'b0;
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (!hold) bus.start = 1'b0;
            if (bus.done) begin
                done_at = cyc;
                return;
            end
            if (bus.busy && !bus.icg_out) clen++;
            if (bus.icg_out && !prev) begin
                if (visits < 16) begin
                    vt[visits] = bus.tester;
                    vg[visits] = bus.gate;
                end
                visits++;
                if (clen != int'(CLR)) clear_bad++;
                clen = 0;
                if (visits == abort_visit) begin
                    bus.icg = 1'b0;
                    return;
                end
            end
            prev = bus.icg_out;
        end
    endtask

    function automatic int table_errors(input int n);
        int e = 0;
        for (int i = 0; i < n && i < 14; i++)
            if (vt[i] !== TAB_T[i] || vg[i] !== TAB_G[i]) e++;
        return e;
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_tester"},    32'(bus.tester),    0);
        check({pfx, "_gate"},      32'(bus.gate),      0);
        check({pfx, "_icg_out"},   32'(bus.icg_out),   0);
        check({pfx, "_busy"},      32'(bus.busy),      0);
        check({pfx, "_done"},      32'(bus.done),      0);
        check({pfx, "_id_valid"},  32'(bus.id_valid),  0);
        check({pfx, "_id_index"},  32'(bus.id_index),  0);
        check({pfx, "_not_found"}, 32'(bus.not_found), 0);
        check({pfx, "_timeout"},   32'(bus.timeout),   0);
        check({pfx, "_aborted"},   32'(bus.aborted),   0);
        check({pfx, "_pass_map"},  32'(bus.pass_map),  0);
    endtask

    initial begin
        int d;
        int dcount;
        bus.start     = 1'b0;
        bus.scan_mode = 1'b0;
        bus.icg       = 1'b1;
        mode          = 0;
        mask          = '0;

        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        @(negedge clk);

        // 1: first match at (1,2), start held high through completion
        mask = 14'h0008; mode = 0; bus.scan_mode = 1'b0;
        run_seq(200, 1'b1, -1, d);
        check("t1_done_at",   32'(d), 37);
        check("t1_visits",    32'(visits), 4);
        check("t1_walk",      32'(table_errors(4)), 0);
        check("t1_id_valid",  32'(bus.id_valid), 1);
        check("t1_id_index",  32'(bus.id_index), 3);
        check("t1_pass_map",  32'(bus.pass_map), 32'h0008);
        check("t1_not_found", 32'(bus.not_found), 0);
        @(negedge clk);
        check("t1_done_pulse", 32'(bus.done), 0);
        check("t1_busy_low",   32'(bus.busy), 0);
        repeat (3) @(negedge clk);
        check("t1_no_restart", 32'(bus.busy), 0);
        bus.start = 1'b0;
        @(negedge clk);

        // 2: full scan with passes at 3 and 10
        mask = 14'h0408; bus.scan_mode = 1'b1;
        run_seq(400, 1'b0, -1, d);
        check("t2_done_at",   32'(d), 127);
        check("t2_visits",    32'(visits), 14);
        check("t2_walk",      32'(table_errors(14)), 0);
        check("t2_clear_len", 32'(clear_bad), 0);
        check("t2_pass_map",  32'(bus.pass_map), 32'h0408);
        check("t2_id_index",  32'(bus.id_index), 3);
        check("t2_id_valid",  32'(bus.id_valid), 1);
        check("t2_not_found", 32'(bus.not_found), 0);
        check("t2_timeout",   32'(bus.timeout), 0);
        repeat (2) @(negedge clk);

        // 3: silent checker, every candidate times out
        mode = 1; bus.scan_mode = 1'b0;
        run_seq(600, 1'b0, -1, d);
        check("t3_done_at",   32'(d), 225);
        check("t3_visits",    32'(visits), 14);
        check("t3_not_found", 32'(bus.not_found), 1);
        check("t3_timeout",   32'(bus.timeout), 1);
        check("t3_pass_map",  32'(bus.pass_map), 0);
        check("t3_id_valid",  32'(bus.id_valid), 0);
        repeat (2) @(negedge clk);

        // 4: pass and fail together at index 0 counts as fail
        mode = 2; mask = 14'h0002; bus.scan_mode = 1'b0;
        run_seq(200, 1'b0, -1, d);
        check("t4_done_at",  32'(d), 19);
        check("t4_visits",   32'(visits), 2);
        check("t4_id_index", 32'(bus.id_index), 1);
        check("t4_pass_map", 32'(bus.pass_map), 32'h0002);
        repeat (2) @(negedge clk);

        // 5: abort in settle of index 5
        mode = 0; mask = 14'h0004; bus.scan_mode = 1'b1;
        run_seq(400, 1'b0, 6, d);
        check("t5_sel", 32'({bus.tester, bus.gate}), 32'({3'd1, 3'd4}));
        @(negedge clk);
        check("t5_busy",     32'(bus.busy), 0);
        check("t5_aborted",  32'(bus.aborted), 1);
        check("t5_icg_out",  32'(bus.icg_out), 0);
        check("t5_id_valid", 32'(bus.id_valid), 0);
        check("t5_pass_map", 32'(bus.pass_map), 32'h0004);
        dcount = int'(bus.done);
        repeat (5) begin
            @(negedge clk);
            dcount += int'(bus.done);
        end
        check("t5_no_done", 32'(dcount), 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_ign_busy",    32'(bus.busy), 0);
        check("t5_ign_aborted", 32'(bus.aborted), 1);

        // restart, then 6: async reset during WAIT of index 1
        bus.icg = 1'b1; mode = 1; bus.scan_mode = 1'b1;
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= 26; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                bus.start = 1'b0;
                check("t5_restart_busy",    32'(bus.busy), 1);
                check("t5_restart_aborted", 32'(bus.aborted), 0);
                check("t5_restart_sel",     32'({bus.tester, bus.gate}), 0);
                check("t5_restart_map",     32'(bus.pass_map), 0);
            end
        end
        check("t6_pre_busy",    32'(bus.busy), 1);
        check("t6_pre_tester",  32'(bus.tester), 1);
        check("t6_pre_timeout", 32'(bus.timeout), 1);
        check("t6_pre_icg_out", 32'(bus.icg_out), 1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("t6");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_idle_busy",    32'(bus.busy), 0);
        check("t6_idle_icg_out", 32'(bus.icg_out), 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("t6_fresh_start", 32'(bus.busy), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
